layer_sequencer: RTL and testbench

Top-level scheduler that runs a layer as a sequence of tiles, driving the matmul, normalization and pooling units one stage at a time per tile over start/done handshakes. It sits above the datapath units, replacing single-shot sequencing with tile iteration, per-stage bypass and a per-stage watchdog. Configuration is latched at launch; status (busy, done, error, tile index) is exported to the host interface.

---
 rtl/tpu_ctrl_pkg.sv | 32 +++
 rtl/layer_sequencer_if.sv | 37 +++
 rtl/stage_watchdog.sv | 35 +++
 rtl/layer_sequencer.sv | 122 ++++++++++++
 tb/tb_layer_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared controller definitions: state encoding, default widths, stage ordering helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package tpu_ctrl_pkg;

   localparam int DEF_TILE_W = 8;
   localparam int DEF_TMO_W  = 16;
   localparam int STATE_W    = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_MATMUL = 3'd1,
      S_NORM   = 3'd2,
      S_POOL   = 3'd3,
      S_NEXT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   // Stage that follows cur, skipping bypassed norm/pool stages.
   function automatic state_t next_stage(input state_t cur, input logic en_norm, input logic en_pool);
      state_t nxt;
      nxt = S_NEXT;
      if (cur == S_MATMUL) begin
         if (en_norm)      nxt = S_NORM;
         else if (en_pool) nxt = S_POOL;
      end else if (cur == S_NORM) begin
         if (en_pool)      nxt = S_POOL;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Host/datapath handshake bundle of the layer sequencer: launch config, stage start/done, status.
// Latency: none (wiring only).
// Backpressure: stage starts are levels held until the matching done is seen.
interface layer_sequencer_if
   import tpu_ctrl_pkg::*;
#(
   parameter int TILE_W = DEF_TILE_W
);
   logic              start;
   logic [TILE_W-1:0] num_tiles;
   logic              enable_norm;
   logic              enable_pool;
   logic              done_mat_mul;
   logic              done_norm;
   logic              done_pool;
   logic              start_mat_mul;
   logic              start_norm;
   logic              start_pool;
   logic [TILE_W-1:0] tile_idx;
   logic              busy;
   logic              done;
   logic              error;

   // Host and datapath side: drives launch/config and the units' done flags.
   modport master (
      output start, num_tiles, enable_norm, enable_pool,
      output done_mat_mul, done_norm, done_pool,
      input  start_mat_mul, start_norm, start_pool, tile_idx, busy, done, error
   );

   // Sequencer side.
   modport slave (
      input  start, num_tiles, enable_norm, enable_pool,
      input  done_mat_mul, done_norm, done_pool,
      output start_mat_mul, start_norm, start_pool, tile_idx, busy, done, error
   );
endinterface

// File: rtl/stage_watchdog.sv
// Per-stage stall counter: cleared on stage entry, counts cycles the stage's done is low.
// Latency: expired_o is combinational, high during the cycle whose count brings the counter to all-ones.
// Backpressure: none; the sequencer decides what to do when it expires.
module stage_watchdog
   import tpu_ctrl_pkg::*;
#(
   parameter int TMO_W = DEF_TMO_W
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);
   localparam logic [TMO_W-1:0] LAST_OK = {TMO_W{1'b1}} - TMO_W'(1);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   // Expiry fires on the increment that makes the counter all-ones, so the
   // stage is aborted exactly 2^TMO_W-1 stalled cycles after entry.
   assign expired_o = inc_i && (cnt_q == LAST_OK);

   // Next count: clear wins, otherwise count stalled cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)    cnt_d = '0;
      else if (inc_i) cnt_d = cnt_q + TMO_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/layer_sequencer.sv
// Layer scheduler: per tile runs matmul, then optional norm and pool, over start/done handshakes.
// Latency: launch->start_mat_mul 1 cycle, stage->stage 1 cycle, NEXT 1 cycle per tile, done the cycle after NEXT.
// Backpressure: each stage waits on its own done; start while busy is dropped; watchdog aborts a stalled stage.
module layer_sequencer
   import tpu_ctrl_pkg::*;
#(
   parameter int TILE_W = DEF_TILE_W,
   parameter int TMO_W  = DEF_TMO_W
) (
   input  logic             clk,
   input  logic             reset,
   layer_sequencer_if.slave bus
);
   state_t            state_q, state_d;
   logic [TILE_W-1:0] tile_idx_q, tile_idx_d;
   logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
   logic              en_norm_q, en_norm_d;
   logic              en_pool_q, en_pool_d;
   logic              error_q, error_d;
   logic              start_mat_mul_q, start_norm_q, start_pool_q;
   logic              busy_q, done_q;
   logic              in_stage, stage_done, last_tile;
   logic              wd_clear, wd_inc, wd_expired;

   // Only the active stage's done is looked at; the others are ignored.
   assign stage_done = ((state_q == S_MATMUL) && bus.done_mat_mul) ||
                       ((state_q == S_NORM)   && bus.done_norm)    ||
                       ((state_q == S_POOL)   && bus.done_pool);
   assign in_stage   = (state_q == S_MATMUL) || (state_q == S_NORM) || (state_q == S_POOL);
   // An empty layer passes through NEXT once, so it also counts as the last tile.
   assign last_tile  = (num_tiles_q == '0) || (tile_idx_q == num_tiles_q - TILE_W'(1));

   assign wd_inc   = in_stage && !stage_done;
   assign wd_clear = (state_d != state_q) &&
                     ((state_d == S_MATMUL) || (state_d == S_NORM) || (state_d == S_POOL));

   stage_watchdog #(.TMO_W(TMO_W)) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (wd_clear),
      .inc_i     (wd_inc),
      .expired_o (wd_expired)
   );

   // Next-state logic: launch/config latch, stage walk with bypass, tile loop, watchdog abort.
   always_comb begin
      state_d     = state_q;
      tile_idx_d  = tile_idx_q;
      num_tiles_d = num_tiles_q;
      en_norm_d   = en_norm_q;
      en_pool_d   = en_pool_q;
      error_d     = error_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_tiles_d = bus.num_tiles;
               en_norm_d   = bus.enable_norm;
               en_pool_d   = bus.enable_pool;
               tile_idx_d  = '0;
               error_d     = 1'b0;
               // Zero tiles skip the datapath; NEXT then routes straight to DONE.
               state_d     = (bus.num_tiles == '0) ? S_NEXT : S_MATMUL;
            end
         end
         S_MATMUL, S_NORM, S_POOL: begin
            if (stage_done) begin
               state_d = next_stage(state_q, en_norm_q, en_pool_q);
            end else if (wd_expired) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_NEXT: begin
            if (last_tile) begin
               state_d = S_DONE;
            end else begin
               tile_idx_d = tile_idx_q + TILE_W'(1);
               state_d    = S_MATMUL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, config and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         tile_idx_q      <= '0;
         num_tiles_q     <= '0;
         en_norm_q       <= 1'b0;
         en_pool_q       <= 1'b0;
         error_q         <= 1'b0;
         start_mat_mul_q <= 1'b0;
         start_norm_q    <= 1'b0;
         start_pool_q    <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         tile_idx_q      <= tile_idx_d;
         num_tiles_q     <= num_tiles_d;
         en_norm_q       <= en_norm_d;
         en_pool_q       <= en_pool_d;
         error_q         <= error_d;
         start_mat_mul_q <= (state_d == S_MATMUL);
         start_norm_q    <= (state_d == S_NORM);
         start_pool_q    <= (state_d == S_POOL);
         busy_q          <= (state_d != S_IDLE);
         done_q          <= (state_d == S_DONE);
      end
   end

   assign bus.start_mat_mul = start_mat_mul_q;
   assign bus.start_norm    = start_norm_q;
   assign bus.start_pool    = start_pool_q;
   assign bus.tile_idx      = tile_idx_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: scoreboard of stage-start and done events plus timing checks.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: a bench-side responder raises each stage's done a set number of cycles after its start.
module tb_layer_sequencer;
   localparam int TILE_W = 8;
   localparam int TMO_W  = 4;
   localparam logic [7:0] EV_M = 8'd1;
   localparam logic [7:0] EV_N = 8'd2;
   localparam logic [7:0] EV_P = 8'd3;
   localparam logic [7:0] EV_D = 8'd4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   layer_sequencer_if #(.TILE_W(TILE_W)) sif ();

   layer_sequencer #(.TILE_W(TILE_W), .TMO_W(TMO_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] exp_q[$];
   logic        prev_m = 1'b0, prev_n = 1'b0, prev_p = 1'b0, prev_done = 1'b0;
   int          done_cnt = 0, done_cyc = 0, dm_cyc = 0, err_cyc = -1, launch_cyc = 0;
   bit          ever_n = 1'b0, ever_p = 1'b0, ever_start = 1'b0;
   bit          resp_en = 1'b0;
   int          resp_dly = 1;
   int          cnt_m = 0, cnt_n = 0, cnt_p = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input logic [7:0] kind, input logic [7:0] tile);
      exp_q.push_back({kind, tile});
   endtask

   task automatic observe(input logic [15:0] ev);
      if (exp_q.size() == 0) check("sb_unexpected", 32'(ev), 32'd0);
      else                   check("sb_event", 32'(ev), 32'(exp_q.pop_front()));
   endtask

   task automatic set_resp(input bit en, input int dly);
      resp_en  = en;
      resp_dly = dly;
      cnt_m = 0; cnt_n = 0; cnt_p = 0;
      sif.done_mat_mul = 1'b0;
      sif.done_norm    = 1'b0;
      sif.done_pool    = 1'b0;
   endtask

   // One clock: sample outputs, feed the scoreboard, then drive the unit responder.
   task automatic tick();
      int s;
      @(posedge clk);
      #1;
      cyc++;
      s = int'(sif.start_mat_mul) + int'(sif.start_norm) + int'(sif.start_pool);
      check("onehot_start", 32'(s <= 1), 32'd1);
      if (sif.start_mat_mul && !prev_m) observe({EV_M, sif.tile_idx});
      if (sif.start_norm && !prev_n)    observe({EV_N, sif.tile_idx});
      if (sif.start_pool && !prev_p)    observe({EV_P, sif.tile_idx});
      if (sif.done) begin
         observe({EV_D, sif.tile_idx});
         check("done_pulse_width", 32'(prev_done), 32'd0);
         done_cnt++;
         done_cyc = cyc;
      end
      if (sif.start_norm) ever_n = 1'b1;
      if (sif.start_pool) ever_p = 1'b1;
      if (s != 0) ever_start = 1'b1;
      if (sif.error && err_cyc < 0) err_cyc = cyc;
      prev_m    = sif.start_mat_mul;
      prev_n    = sif.start_norm;
      prev_p    = sif.start_pool;
      prev_done = sif.done;
      if (resp_en) begin
         cnt_m = sif.start_mat_mul ? cnt_m + 1 : 0;
         cnt_n = sif.start_norm    ? cnt_n + 1 : 0;
         cnt_p = sif.start_pool    ? cnt_p + 1 : 0;
         sif.done_mat_mul = (cnt_m == resp_dly);
         sif.done_norm    = (cnt_n == resp_dly);
         sif.done_pool    = (cnt_p == resp_dly);
         if (sif.done_mat_mul) dm_cyc = cyc;
      end
   endtask

   task automatic launch(input logic [7:0] n, input logic en_n, input logic en_p);
      sif.num_tiles   = n;
      sif.enable_norm = en_n;
      sif.enable_pool = en_p;
      sif.start       = 1'b1;
      launch_cyc      = cyc;
      tick();
      sif.start       = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int base;
      int n;
      base = done_cnt;
      n    = 0;
      while (done_cnt == base && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      int n;
      reset            = 1'b1;
      sif.start        = 1'b0;
      sif.num_tiles    = '0;
      sif.enable_norm  = 1'b0;
      sif.enable_pool  = 1'b0;
      set_resp(1'b0, 1);
      tick();
      tick();
      check("rst_busy", sif.busy, 1'b0);
      check("rst_done", sif.done, 1'b0);
      check("rst_error", sif.error, 1'b0);
      check("rst_tile_idx", 32'(sif.tile_idx), 32'd0);
      check("rst_starts", {sif.start_mat_mul, sif.start_norm, sif.start_pool}, 3'b000);
      reset = 1'b0;
      tick();

      // Three tiles, all stages, each unit answers after 5 cycles.
      set_resp(1'b1, 5);
      for (int t = 0; t < 3; t++) begin
         push_ev(EV_M, 8'(t));
         push_ev(EV_N, 8'(t));
         push_ev(EV_P, 8'(t));
      end
      push_ev(EV_D, 8'd2);
      launch(8'd3, 1'b1, 1'b1);
      check("t1_launch_mm", sif.start_mat_mul, 1'b1);
      check("t1_launch_busy", sif.busy, 1'b1);
      run_until_done("t1_done", 200);
      tick();
      check("t1_busy_after", sif.busy, 1'b0);
      check("t1_tile_hold", 32'(sif.tile_idx), 32'd2);
      check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Two tiles, norm and pool bypassed.
      set_resp(1'b1, 3);
      ever_n = 1'b0;
      ever_p = 1'b0;
      push_ev(EV_M, 8'd0);
      push_ev(EV_M, 8'd1);
      push_ev(EV_D, 8'd1);
      launch(8'd2, 1'b0, 1'b0);
      run_until_done("t2_done", 100);
      check("t2_done_latency", 32'(done_cyc - dm_cyc), 32'd2);
      check("t2_no_norm", 32'(ever_n), 32'd0);
      check("t2_no_pool", 32'(ever_p), 32'd0);
      tick();

      // Empty layer: done two cycles after the launch edge, no stage ever started.
      ever_start = 1'b0;
      push_ev(EV_D, 8'd0);
      launch(8'd0, 1'b1, 1'b1);
      check("t3_busy", sif.busy, 1'b1);
      run_until_done("t3_done", 10);
      check("t3_done_latency", 32'(done_cyc - launch_cyc), 32'd2);
      check("t3_no_start", 32'(ever_start), 32'd0);
      tick();

      // Foreign dones and a second start during MATMUL are ignored; config stays latched.
      set_resp(1'b0, 1);
      push_ev(EV_M, 8'd0);
      push_ev(EV_N, 8'd0);
      push_ev(EV_D, 8'd0);
      launch(8'd1, 1'b1, 1'b0);
      sif.done_norm = 1'b1;
      sif.done_pool = 1'b1;
      sif.start     = 1'b1;
      sif.num_tiles = 8'd5;
      tick();
      check("t4_still_mm", sif.start_mat_mul, 1'b1);
      check("t4_no_norm", sif.start_norm, 1'b0);
      sif.start        = 1'b0;
      sif.done_pool    = 1'b0;
      sif.done_mat_mul = 1'b1;
      tick();
      check("t4_in_norm", sif.start_norm, 1'b1);
      sif.done_mat_mul = 1'b0;
      sif.done_norm    = 1'b0;
      tick();
      check("t4_norm_held", sif.start_norm, 1'b1);
      sif.done_norm = 1'b1;
      tick();
      check("t4_next_norm_low", sif.start_norm, 1'b0);
      check("t4_next_busy", sif.busy, 1'b1);
      sif.done_norm = 1'b0;
      run_until_done("t4_done", 3);
      tick();
      check("t4_busy_after", sif.busy, 1'b0);
      check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

      // Watchdog: matmul never answers.
      set_resp(1'b0, 1);
      err_cyc = -1;
      n = done_cnt;
      push_ev(EV_M, 8'd0);
      launch(8'd2, 1'b0, 1'b0);
      for (int i = 0; i < 40 && err_cyc < 0; i++) tick();
      check("t5_err_cycle", 32'(err_cyc - launch_cyc), 32'd16);
      check("t5_error", sif.error, 1'b1);
      check("t5_mm_low", sif.start_mat_mul, 1'b0);
      check("t5_idle", sif.busy, 1'b0);
      tick();
      tick();
      check("t5_sticky", sif.error, 1'b1);
      check("t5_no_done", 32'(done_cnt - n), 32'd0);
      set_resp(1'b1, 1);
      push_ev(EV_M, 8'd0);
      push_ev(EV_D, 8'd0);
      launch(8'd1, 1'b0, 1'b0);
      check("t5_err_cleared", sif.error, 1'b0);
      run_until_done("t5_relaunch_done", 10);
      tick();

      // Reset in the middle of the second tile's NORM stage.
      set_resp(1'b1, 5);
      push_ev(EV_M, 8'd0);
      push_ev(EV_N, 8'd0);
      push_ev(EV_M, 8'd1);
      push_ev(EV_N, 8'd1);
      launch(8'd3, 1'b1, 1'b0);
      n = 0;
      while (!(sif.start_norm && sif.tile_idx == 8'd1) && n < 100) begin
         tick();
         n++;
      end
      check("t6_reached_norm1", 32'(sif.start_norm && sif.tile_idx == 8'd1), 32'd1);
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t6_rst_starts", {sif.start_mat_mul, sif.start_norm, sif.start_pool}, 3'b000);
      check("t6_rst_busy", sif.busy, 1'b0);
      check("t6_rst_done", sif.done, 1'b0);
      check("t6_rst_error", sif.error, 1'b0);
      check("t6_rst_tile_idx", 32'(sif.tile_idx), 32'd0);
      check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
      reset = 1'b0;
      tick();
      push_ev(EV_M, 8'd0);
      push_ev(EV_N, 8'd0);
      push_ev(EV_P, 8'd0);
      push_ev(EV_D, 8'd0);
      launch(8'd1, 1'b1, 1'b1);
      run_until_done("t6_fresh_done", 100);
      tick();
      check("t6_fresh_idle", sif.busy, 1'b0);
      check("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, required finish");
      $fatal(1, "simulation time limit");
   end
endmodule
